// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I width
// codes and the request legality check used at accept time.
package lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Returns 1 when a request must be rejected without touching memory:
    // unknown width code, unsigned width on a store, misaligned halfword or
    // word, or a byte address beyond the reach of the memory unit.
    function automatic logic lsu_req_err(
        input logic        we,
        input logic [2:0]  funct3,
        input logic [31:0] addr,
        input int          aw
    );
        logic bad_s;
        bad_s = 1'b0;
        case (funct3)
            F3_B:    bad_s = 1'b0;
            F3_H:    bad_s = addr[0];
            F3_W:    bad_s = (addr[1:0] != 2'b00);
            F3_BU:   bad_s = we;
            F3_HU:   bad_s = we | addr[0];
            default: bad_s = 1'b1;
        endcase
        if ((addr >> (aw + 2)) != 32'd0) begin
            bad_s = 1'b1;
        end else begin
            bad_s = bad_s;
        end
        return bad_s;
    endfunction

endpackage

// File: rtl/lsu_align_v1.sv
// Lane handling for sub-word accesses: extracts and extends load data from
// a memory word, and merges store data into a word for read-modify-write.
module lsu_align_v1
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte/halfword and extend it to 32 bits.
    always_comb begin
        byte_s    = 8'd0;
        half_s    = 16'd0;
        load_data = 32'd0;
        case (lane)
            2'd0:    byte_s = word[7:0];
            2'd1:    byte_s = word[15:8];
            2'd2:    byte_s = word[23:16];
            2'd3:    byte_s = word[31:24];
            default: byte_s = word[7:0];
        endcase
        if (lane[1]) begin
            half_s = word[31:16];
        end else begin
            half_s = word[15:0];
        end
        case (funct3)
            F3_B:    load_data = {{24{byte_s[7]}}, byte_s};
            F3_BU:   load_data = {24'd0, byte_s};
            F3_H:    load_data = {{16{half_s[15]}}, half_s};
            F3_HU:   load_data = {16'd0, half_s};
            F3_W:    load_data = word;
            default: load_data = 32'd0;
        endcase
    end

    // Overwrite the addressed byte/halfword of the captured word with store data.
    always_comb begin
        merged = word;
        case (funct3)
            F3_B:    merged[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    merged[{lane[1], 4'b0000} +: 16] = wdata;
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/lsu_v1.sv
// Load/store unit: accepts one RV32I load/store at a time, checks legality,
// and sequences a single-port synchronous memory (read-modify-write for
// byte/halfword stores). All outputs come straight from registers.
module lsu_v1
    import lsu_pkg::*;
#(
    parameter int addr_width = 10,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_wdata,
    input  logic [data_width-1:0] mem_rdata,
    output logic                  mem_write_enable,
    output logic                  mem_read_enable
);

    lsu_state_t state_r, state_nx_s;

    // Captured request. Only the low half of store data is kept: full-word
    // stores are issued straight from the request on the accepting edge.
    logic                  we_r;
    logic [2:0]            funct3_r;
    logic [1:0]            lane_r;
    logic [addr_width-1:0] word_r;
    logic [15:0]           wdata_r;

    logic                  busy_r;
    logic                  resp_valid_r, resp_err_r;
    logic [31:0]           resp_rdata_r;
    logic [addr_width-1:0] mem_addr_r;
    logic [data_width-1:0] mem_wdata_r;
    logic                  mem_we_r, mem_re_r;

    logic                  accept_s, req_err_s, is_sw_s;
    logic                  resp_valid_nx_s, resp_err_nx_s;
    logic [31:0]           resp_rdata_nx_s;
    logic [addr_width-1:0] mem_addr_nx_s;
    logic [data_width-1:0] mem_wdata_nx_s;
    logic                  mem_we_nx_s, mem_re_nx_s;
    logic [31:0]           load_s, merged_s;

    assign accept_s  = req_valid & (state_r == ST_IDLE);
    assign req_err_s = lsu_req_err(req_we, req_funct3, req_addr, addr_width);
    assign is_sw_s   = we_r & (funct3_r == F3_W);

    lsu_align_v1 u_align (
        .funct3    (funct3_r),
        .lane      (lane_r),
        .word      (mem_rdata),
        .wdata     (wdata_r),
        .load_data (load_s),
        .merged    (merged_s)
    );

    // Next state plus the values every output register takes in that state.
    always_comb begin
        state_nx_s      = state_r;
        resp_valid_nx_s = 1'b0;
        resp_err_nx_s   = 1'b0;
        resp_rdata_nx_s = 32'd0;
        mem_addr_nx_s   = {addr_width{1'b0}};
        mem_wdata_nx_s  = {data_width{1'b0}};
        mem_we_nx_s     = 1'b0;
        mem_re_nx_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (req_err_s) begin
                        state_nx_s      = ST_RESP;
                        resp_valid_nx_s = 1'b1;
                        resp_err_nx_s   = 1'b1;
                    end else begin
                        state_nx_s    = ST_ISSUE;
                        mem_addr_nx_s = req_addr[addr_width+1:2];
                        if (req_we && (req_funct3 == F3_W)) begin
                            mem_we_nx_s    = 1'b1;
                            mem_wdata_nx_s = req_wdata;
                        end else begin
                            mem_re_nx_s = 1'b1;
                        end
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (is_sw_s) begin
                    state_nx_s      = ST_RESP;
                    resp_valid_nx_s = 1'b1;
                end else begin
                    state_nx_s = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (we_r) begin
                    state_nx_s     = ST_WRITE;
                    mem_we_nx_s    = 1'b1;
                    mem_addr_nx_s  = word_r;
                    mem_wdata_nx_s = merged_s;
                end else begin
                    state_nx_s      = ST_RESP;
                    resp_valid_nx_s = 1'b1;
                    resp_rdata_nx_s = load_s;
                end
            end
            ST_WRITE: begin
                state_nx_s      = ST_RESP;
                resp_valid_nx_s = 1'b1;
            end
            ST_RESP: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State, captured request and output registers; reset abandons any operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            we_r         <= 1'b0;
            funct3_r     <= 3'd0;
            lane_r       <= 2'd0;
            word_r       <= {addr_width{1'b0}};
            wdata_r      <= 16'd0;
            busy_r       <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 32'd0;
            mem_addr_r   <= {addr_width{1'b0}};
            mem_wdata_r  <= {data_width{1'b0}};
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            busy_r       <= (state_nx_s != ST_IDLE);
            resp_valid_r <= resp_valid_nx_s;
            resp_err_r   <= resp_err_nx_s;
            resp_rdata_r <= resp_rdata_nx_s;
            mem_addr_r   <= mem_addr_nx_s;
            mem_wdata_r  <= mem_wdata_nx_s;
            mem_we_r     <= mem_we_nx_s;
            mem_re_r     <= mem_re_nx_s;
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                lane_r   <= req_addr[1:0];
                word_r   <= req_addr[addr_width+1:2];
                wdata_r  <= req_wdata[15:0];
            end else begin
                we_r     <= we_r;
                funct3_r <= funct3_r;
                lane_r   <= lane_r;
                word_r   <= word_r;
                wdata_r  <= wdata_r;
            end
        end
    end

    assign req_ready        = ~busy_r;
    assign resp_valid       = resp_valid_r;
    assign resp_err         = resp_err_r;
    assign resp_rdata       = resp_rdata_r;
    assign mem_addr         = mem_addr_r;
    assign mem_wdata        = mem_wdata_r;
    assign mem_write_enable = mem_we_r;
    assign mem_read_enable  = mem_re_r;

endmodule

// File: tb/tb_lsu_v1.sv
// Self-checking bench for lsu_v1: directed table, reset and back-to-back
// sequences, then random requests against a byte-level reference model.
module tb_lsu_v1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata_q;
    logic        mem_write_enable, mem_read_enable;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_v1 dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata_q), .mem_write_enable(mem_write_enable),
        .mem_read_enable(mem_read_enable)
    );

    // Synchronous single-port memory with a bench-side preload port.
    logic [31:0] mem [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'd0;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_write_enable) mem[mem_addr] <= mem_wdata;
        if (mem_read_enable) mem_rdata_q <= mem[mem_addr];
    end

    // Interface invariants checked every cycle while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if ((mem_read_enable && mem_write_enable) ||
                (!resp_valid && (resp_err || resp_rdata != 32'd0)) ||
                (!mem_read_enable && !mem_write_enable && mem_addr != 10'd0)) begin
                errors++;
                $display("FAIL protocol re=%b we=%b rv=%b err=%b rdata=%h addr=%h",
                         mem_read_enable, mem_write_enable, resp_valid, resp_err, resp_rdata, mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issue one request from idle and observe up to 10 cycles after the accept edge.
    task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata,
                           output logic g_err, output logic [31:0] g_rdata, output int g_lat,
                           output int rd_k, output logic [9:0] rd_addr,
                           output int wr_k, output logic [31:0] wr_data, output logic [9:0] wr_addr,
                           output int n_str, output logic busy_ok);
        @(negedge clk);
        chk("ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        g_err = 1'b0; g_rdata = 32'd0; g_lat = -1; rd_k = 0; rd_addr = 10'd0;
        wr_k = 0; wr_data = 32'd0; wr_addr = 10'd0; n_str = 0; busy_ok = 1'b1;
        for (int k = 1; k <= 10 && g_lat < 0; k++) begin
            @(negedge clk);
            if (req_ready) busy_ok = 1'b0;
            if (mem_read_enable || mem_write_enable) n_str++;
            if (mem_read_enable && rd_k == 0) begin rd_k = k; rd_addr = mem_addr; end
            if (mem_write_enable && wr_k == 0) begin wr_k = k; wr_data = mem_wdata; wr_addr = mem_addr; end
            if (resp_valid) begin g_lat = k; g_err = resp_err; g_rdata = resp_rdata; end
            if (k == 1) req_valid = 1'b0;
        end
    endtask

    // Reference model: byte-addressed memory and the RV32I access rules.
    logic [7:0] ref_bytes [0:4095];

    function automatic void ref_exec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                     input logic [31:0] wdata, output logic err,
                                     output logic [31:0] rdata, output int lat);
        int size; logic sgn; longint v;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: begin size = 4; sgn = 1'b0; end
            3'd4: begin size = 1; sgn = 1'b0; end
            3'd5: begin size = 2; sgn = 1'b0; end
            default: begin size = 0; sgn = 1'b0; end
        endcase
        err = (size == 0) || (we && (f3 == 3'd4 || f3 == 3'd5)) ||
              ((size != 0) && (addr % size != 0)) || (addr >= 32'd4096);
        rdata = 32'd0;
        if (err) lat = 1;
        else if (we) begin
            for (int i = 0; i < size; i++) ref_bytes[addr + i] = wdata[8*i +: 8];
            lat = (size == 4) ? 2 : 4;
        end else begin
            v = 0;
            for (int i = 0; i < size; i++) v += longint'(ref_bytes[addr + i]) << (8 * i);
            if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
            rdata = v[31:0];
            lat = 3;
        end
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {ref_bytes[4*w+3], ref_bytes[4*w+2], ref_bytes[4*w+1], ref_bytes[4*w]};
    endfunction

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_wword;
    } vec_t;

    vec_t vecs [16];

    initial begin
        logic g_err, busy_ok;
        logic [31:0] g_rdata, wr_data, last_rd, e_rdata;
        logic [9:0] rd_addr, wr_addr;
        int g_lat, rd_k, wr_k, n_str, e_lat, e_rd, e_wr, e_n, seen_k, nresp;
        logic e_err, any_act;
        logic [7:0] rdy_pat, resp_pat;
        logic [31:0] addr, wdata;
        logic [2:0] f3;
        logic we;

        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h8000_00F0, 3, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h05, 32'h0,        1'b0, 32'hFFFF_FF80, 3, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h05, 32'h0,        1'b0, 32'h0000_0080, 3, 32'h0};
        vecs[3]  = '{1'b1, 3'b000, 32'h0A, 32'hAB,       1'b0, 32'h0,         4, 32'h11AB_3344};
        vecs[4]  = '{1'b0, 3'b010, 32'h08, 32'h0,        1'b0, 32'h11AB_3344, 3, 32'h0};
        vecs[5]  = '{1'b0, 3'b010, 32'h06, 32'h0,        1'b1, 32'h0,         1, 32'h0};
        vecs[6]  = '{1'b1, 3'b001, 32'h03, 32'h1234,     1'b1, 32'h0,         1, 32'h0};
        vecs[7]  = '{1'b0, 3'b011, 32'h00, 32'h0,        1'b1, 32'h0,         1, 32'h0};
        vecs[8]  = '{1'b0, 3'b010, 32'h1000, 32'h0,      1'b1, 32'h0,         1, 32'h0};
        vecs[9]  = '{1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 1'b0, 32'h0,        2, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 3'b001, 32'h22, 32'h0,        1'b0, 32'hFFFF_DEAD, 3, 32'h0};
        vecs[11] = '{1'b0, 3'b101, 32'h20, 32'h0,        1'b0, 32'h0000_BEEF, 3, 32'h0};
        vecs[12] = '{1'b1, 3'b001, 32'h22, 32'hFFFF_1234, 1'b0, 32'h0,        4, 32'h1234_BEEF};
        vecs[13] = '{1'b0, 3'b100, 32'h23, 32'h0,        1'b0, 32'h0000_0012, 3, 32'h0};
        vecs[14] = '{1'b1, 3'b100, 32'h20, 32'h55,       1'b1, 32'h0,         1, 32'h0};
        vecs[15] = '{1'b0, 3'b000, 32'h21, 32'h0,        1'b0, 32'hFFFF_FFBE, 3, 32'h0};

        // Reset state, with memory preloaded meanwhile.
        preload(10'd4, 32'h8000_00F0);
        preload(10'd1, 32'h0000_8000);
        preload(10'd2, 32'h1122_3344);
        preload(10'd5, 32'hCAFE_F00D);
        @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_strobes", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
        rst = 1'b1;

        // Directed table.
        for (int i = 0; i < 16; i++) begin
            run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, g_err, g_rdata, g_lat,
                    rd_k, rd_addr, wr_k, wr_data, wr_addr, n_str, busy_ok);
            e_rd = (!vecs[i].exp_err && !(vecs[i].we && vecs[i].f3 == 3'b010)) ? 1 : 0;
            e_wr = (!vecs[i].exp_err && vecs[i].we) ? vecs[i].exp_lat - 1 : 0;
            e_n  = vecs[i].exp_err ? 0 : (vecs[i].we && vecs[i].f3 != 3'b010) ? 2 : 1;
            chk($sformatf("v%0d_lat", i), 32'(g_lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_err", i), {31'd0, g_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), g_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_read_cycle", i), 32'(rd_k), 32'(e_rd));
            chk($sformatf("v%0d_write_cycle", i), 32'(wr_k), 32'(e_wr));
            chk($sformatf("v%0d_strobes", i), 32'(n_str), 32'(e_n));
            chk($sformatf("v%0d_ready_low", i), {31'd0, busy_ok}, 32'd1);
            if (e_rd != 0) chk($sformatf("v%0d_read_addr", i), {22'd0, rd_addr}, vecs[i].addr >> 2);
            if (e_wr != 0) begin
                chk($sformatf("v%0d_write_data", i), wr_data, vecs[i].exp_wword);
                chk($sformatf("v%0d_write_addr", i), {22'd0, wr_addr}, vecs[i].addr >> 2);
            end
        end

        // Reset during CAPTURE of an SH: no write, no response, memory untouched.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h14; req_wdata = 32'h5555;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstmid_read_issued", {31'd0, mem_read_enable}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_ready", {31'd0, req_ready}, 32'd1);
        chk("rstmid_write", {31'd0, mem_write_enable}, 32'd0);
        chk("rstmid_resp", {31'd0, resp_valid}, 32'd0);
        rst = 1'b1;
        any_act = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (mem_write_enable || mem_read_enable || resp_valid) any_act = 1'b1;
        end
        chk("rstmid_quiet", {31'd0, any_act}, 32'd0);
        chk("rstmid_mem", mem[5], 32'hCAFE_F00D);

        // Back-to-back: SW then LW to the same address with req_valid held high.
        @(negedge clk);
        chk("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h0BAD_CAFE;
        @(posedge clk);
        rdy_pat = 8'd0; resp_pat = 8'd0; seen_k = 0; nresp = 0; last_rd = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rdy_pat[k-1] = req_ready;
            resp_pat[k-1] = resp_valid;
            if (resp_valid) begin nresp++; last_rd = resp_rdata; end
            if (k == 1) begin req_we = 1'b0; req_wdata = 32'd0; end
            if (seen_k != 0 && k == seen_k + 1) req_valid = 1'b0;
            if (req_ready && seen_k == 0) seen_k = k;
        end
        req_valid = 1'b0;
        chk("b2b_ready_pattern", {24'd0, rdy_pat}, 32'h0000_00C4);
        chk("b2b_resp_pattern", {24'd0, resp_pat}, 32'h0000_0022);
        chk("b2b_resp_count", 32'(nresp), 32'd2);
        chk("b2b_lw_data", last_rd, 32'h0BAD_CAFE);
        chk("b2b_mem", mem[12], 32'h0BAD_CAFE);

        // Random traffic against the reference model.
        for (int w = 0; w < 16; w++) preload(10'(w), $urandom);
        @(negedge clk);
        for (int b = 0; b < 4096; b++) ref_bytes[b] = mem[b / 4][8*(b % 4) +: 8];
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) addr[0] = 1'b0;
                if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
            end
            if ($urandom_range(0, 15) == 0) addr = addr | (32'h1000 << $urandom_range(0, 19));
            wdata = $urandom;
            ref_exec(we, f3, addr, wdata, e_err, e_rdata, e_lat);
            run_req(we, f3, addr, wdata, g_err, g_rdata, g_lat, rd_k, rd_addr,
                    wr_k, wr_data, wr_addr, n_str, busy_ok);
            e_n = (e_lat == 1) ? 0 : (e_lat == 4) ? 2 : 1;
            chk($sformatf("r%0d_err", n), {31'd0, g_err}, {31'd0, e_err});
            chk($sformatf("r%0d_rdata", n), g_rdata, e_rdata);
            chk($sformatf("r%0d_lat", n), 32'(g_lat), 32'(e_lat));
            chk($sformatf("r%0d_strobes", n), 32'(n_str), 32'(e_n));
            if (!e_err && we) chk($sformatf("r%0d_write_word", n), wr_data, ref_word(int'(addr >> 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_v1.md
LSU_V1 -- requirements
Module: lsu_v1

Interface
REQ-001 SHALL have parameter addr_width, default 10, word-address width of the memory unit.
REQ-002 SHALL have parameter data_width, default 32, memory word width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  output  1  block accepts a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  output  1  request rejected, with no memory access.
REQ-014 SHALL have port mem_addr  output  addr_width  word address to the memory unit.
REQ-015 SHALL have port mem_wdata  output  data_width  word to the memory unit data input.
REQ-016 SHALL have port mem_rdata  input  data_width  word from the memory unit data output; valid one cycle after a read is issued.
REQ-017 SHALL have ports mem_write_enable and mem_read_enable  output  1 each  memory strobes.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, CAPTURE, WRITE, RESP.
REQ-019 SHALL assert req_ready only in IDLE and SHALL register all request fields on the accepting edge.
REQ-020 SHALL treat a request as an error if any of the following hold:
- funct3 is 011, 110 or 111;
- a store uses funct3 100 or 101;
- an H access has addr[0]=1;
- a W access has addr[1:0]!=0;
- addr[31:addr_width+2]!=0.
REQ-021 SHALL move an accepted error request IDLE->RESP, giving resp_valid=1 and resp_err=1 at accept+1 with no memory strobe.
REQ-022 SHALL drive mem_addr = addr[addr_width+1:2] in ISSUE and WRITE, and 0 elsewhere.
REQ-023 SHALL, in ISSUE, handle each request type as follows:
- SW: mem_write_enable=1, mem_wdata=req_wdata, next state RESP.
- Loads and SB/SH: mem_read_enable=1, next state CAPTURE.
REQ-024 SHALL, in CAPTURE, handle each request type as follows:
- Loads: select the lane by addr[1:0], sign-extend (B/H) or zero-extend (BU/HU), register into resp_rdata, next state RESP.
- SB/SH: merge req_wdata low byte/half into the captured word at the addressed lane, next state WRITE.
REQ-025 SHALL, in WRITE, drive mem_write_enable=1 with the merged word, next state RESP.
REQ-026 SHALL hold resp_valid=1 for exactly one cycle in RESP, then return to IDLE; there is no response backpressure.
REQ-027 SHALL never assert mem_read_enable and mem_write_enable in the same cycle.
REQ-028 SHALL meet these latencies from the accept edge T: error T+1; SW T+2; loads T+3; SB/SH T+4.
REQ-029 SHALL drive resp_rdata and resp_err as 0 whenever resp_valid=0.

Reset
REQ-030 SHALL, when rst=0 at a clock edge, enter IDLE and zero all registers, including any operation in progress.
REQ-031 SHALL, in the cycle after reset, hold these output values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_wdata=0, both strobes 0.
REQ-032 SHALL, on reset in the middle of an operation, produce no resp_valid and no further strobe for that request; a partial read-modify-write leaves memory unmodified.

Structure
REQ-033 SHALL take the state enum, funct3 width codes and the error-check helper from a shared package lsu_pkg.
REQ-034 SHALL place lane extract/extend and lane merge in a combinational sub-module lsu_align_v1.

Verification
REQ-035 SHALL verify LW: mem word 0x8000_00F0 at word 4; LW addr 0x10 -> mem_read_enable at T+1 with mem_addr=4, resp_valid at T+3 with resp_rdata=0x8000_00F0.
REQ-036 SHALL verify LB and LBU: word 0x0000_8000 at word 1; LB addr 0x05 -> resp_rdata=0xFFFF_FF80; LBU addr 0x05 -> 0x0000_0080.
REQ-037 SHALL verify SB read-modify-write: word 0x1122_3344 at word 2; SB addr 0x0A with wdata 0xAB -> read at T+1, write 0x11AB_3344 at T+3, resp_valid at T+4.
REQ-038 SHALL verify errors: LW addr 0x06, SH addr 0x03, funct3 011, and addr 0x0000_1000 with addr_width=10 -> resp_err=1 at T+1 and no strobe.
REQ-039 SHALL verify reset mid-operation: rst=0 during the CAPTURE of an SH -> no WRITE strobe, no resp_valid, memory word unchanged, req_ready=1 the cycle after.
REQ-040 SHALL verify back-to-back traffic: req_valid held high for SW then LW to the same address -> req_ready low while busy, the LW returns the stored data, and strobes never overlap.
